// File: rtl/mcs4_clock_gen_pkg.sv
// rtl/mcs4_clock_gen_pkg.sv - shared phase codes, clock FSM states and tick-load helper for mcs4_clock_gen
package mcs4_clock_gen_pkg;

  typedef enum logic [1:0] {
    ST_C1 = 2'd0,
    ST_G1 = 2'd1,
    ST_C2 = 2'd2,
    ST_G2 = 2'd3
  } clk_state_t;

  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X1 = 3'd5;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  // Counters count down to zero, so a state lasting N ticks loads N-1.
  function automatic logic [7:0] tick_load(input int ticks);
    return 8'(ticks - 1);
  endfunction

endpackage

// File: rtl/mcs4_poc_timer.sv
// rtl/mcs4_poc_timer.sv - power-on-clear hold timer counting clock-period boundaries
module mcs4_poc_timer #(
  parameter int POC_PERIODS = 64
) (
  input  logic sysclk,
  input  logic poc,
  input  logic boundary,
  output logic poc_pad
);

  localparam logic [7:0] POC_LAST = 8'(POC_PERIODS);

  logic [7:0] period_cnt;

  // The first boundary after reset opens period 1, so poc_pad falls on boundary POC_PERIODS+1.
  always_ff @(posedge sysclk) begin
    if (poc) begin
      period_cnt <= 8'd0;
      poc_pad    <= 1'b1;
    end else if (boundary && poc_pad) begin
      if (period_cnt == POC_LAST) begin
        poc_pad <= 1'b0;
      end else begin
        period_cnt <= period_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/mcs4_clock_gen.sv
// rtl/mcs4_clock_gen.sv - MCS-4 two-phase clock generator with run/halt/step and instruction-cycle phase tracking
module mcs4_clock_gen
  import mcs4_clock_gen_pkg::*;
#(
  parameter int CLK1_TICKS  = 20,
  parameter int GAP1_TICKS  = 14,
  parameter int CLK2_TICKS  = 20,
  parameter int GAP2_TICKS  = 14,
  parameter int POC_PERIODS = 64
) (
  input  logic       sysclk,
  input  logic       poc,
  input  logic       run,
  input  logic       step,
  input  logic       sync_pad,
  output logic       clk1_pad,
  output logic       clk2_pad,
  output logic       poc_pad,
  output logic       halted,
  output logic [2:0] phase,
  output logic       phase_valid,
  output logic       cycle_strobe
);

  localparam logic [7:0] CLK1_LOAD = tick_load(CLK1_TICKS);
  localparam logic [7:0] GAP1_LOAD = tick_load(GAP1_TICKS);
  localparam logic [7:0] CLK2_LOAD = tick_load(CLK2_TICKS);
  localparam logic [7:0] GAP2_LOAD = tick_load(GAP2_TICKS);

  clk_state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       step_pending, pend_nx;
  logic       sync_q;
  logic       last_tick, at_end, go, boundary;

  assign last_tick = (cnt == 8'd0);
  assign at_end    = (state == ST_G2) && last_tick;
  assign go        = run | step | step_pending;
  assign boundary  = at_end & go;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = step_pending;
    if (!last_tick) begin
      cnt_nx = cnt - 8'd1;
    end else begin
      case (state)
        ST_C1: begin state_nx = ST_G1; cnt_nx = GAP1_LOAD; end
        ST_G1: begin state_nx = ST_C2; cnt_nx = CLK2_LOAD; end
        ST_C2: begin state_nx = ST_G2; cnt_nx = GAP2_LOAD; end
        ST_G2: begin
          if (go) begin
            state_nx = ST_C1;
            cnt_nx   = CLK1_LOAD;
          end
        end
        default: begin state_nx = ST_G2; cnt_nx = 8'd0; end
      endcase
    end
    // run dominates step; a pending step is consumed by the C1 entry it grants
    if (run || boundary) begin
      pend_nx = 1'b0;
    end else if (step) begin
      pend_nx = 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (poc) begin
      state        <= ST_G2;
      cnt          <= 8'd0;
      clk1_pad     <= 1'b0;
      clk2_pad     <= 1'b0;
      halted       <= 1'b0;
      phase        <= PH_A1;
      phase_valid  <= 1'b0;
      cycle_strobe <= 1'b0;
      step_pending <= 1'b0;
      sync_q       <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      clk1_pad     <= (state_nx == ST_C1);
      clk2_pad     <= (state_nx == ST_C2);
      halted       <= at_end & ~go;
      step_pending <= pend_nx;
      cycle_strobe <= 1'b0;
      if (state == ST_C2 && last_tick) begin
        sync_q <= sync_pad;
      end
      // SYNC marks X3, so the period after it is A1
      if (boundary) begin
        if (sync_q) begin
          phase        <= PH_A1;
          phase_valid  <= 1'b1;
          cycle_strobe <= 1'b1;
        end else begin
          phase        <= phase + 3'd1;
          cycle_strobe <= (phase == PH_X3) && phase_valid;
        end
      end
    end
  end

  mcs4_poc_timer #(
    .POC_PERIODS(POC_PERIODS)
  ) u_poc_timer (
    .sysclk  (sysclk),
    .poc     (poc),
    .boundary(boundary),
    .poc_pad (poc_pad)
  );

endmodule

// File: tb/tb_mcs4_clock_gen.sv
// tb/tb_mcs4_clock_gen.sv - self-checking bench for mcs4_clock_gen against a period-position reference model
module tb_mcs4_clock_gen;

  localparam int C1 = 20, G1 = 14, C2 = 20, G2 = 14;
  localparam int PER = C1 + G1 + C2 + G2;
  localparam int POCN = 4;

  logic sysclk = 1'b0;
  logic poc = 1'b1, run = 1'b0, step = 1'b0, sync_pad = 1'b0;
  logic clk1_pad, clk2_pad, poc_pad, halted, phase_valid, cycle_strobe;
  logic [2:0] phase;
  logic [8:0] dut_vec;

  int checks = 0, errors = 0;
  int tick_idx = 0;

  // reference model: position within the period, plus bookkeeping from the rules
  int m_pos = PER - 1, m_nbound = 0, m_phase = 0;
  bit m_halt = 0, m_pocp = 1, m_pv = 0, m_strobe = 0, m_pend = 0, m_sync = 0;

  always #5 sysclk = ~sysclk;

  mcs4_clock_gen #(
    .CLK1_TICKS(C1), .GAP1_TICKS(G1), .CLK2_TICKS(C2), .GAP2_TICKS(G2), .POC_PERIODS(POCN)
  ) dut (
    .sysclk(sysclk), .poc(poc), .run(run), .step(step), .sync_pad(sync_pad),
    .clk1_pad(clk1_pad), .clk2_pad(clk2_pad), .poc_pad(poc_pad), .halted(halted),
    .phase(phase), .phase_valid(phase_valid), .cycle_strobe(cycle_strobe)
  );

  assign dut_vec = {poc_pad, clk1_pad, clk2_pad, halted, phase_valid, cycle_strobe, phase};

  always @(posedge sysclk) begin
    if (poc) begin
      m_pos = PER - 1; m_halt = 0; m_pocp = 1; m_nbound = 0; m_phase = 0;
      m_pv = 0; m_strobe = 0; m_pend = 0; m_sync = 0;
    end else begin
      m_strobe = 0;
      if (m_pos == PER - 1) begin
        if (run || step || m_pend) begin
          m_pos = 0; m_halt = 0; m_pend = 0;
          m_nbound++;
          if (m_nbound > POCN) m_pocp = 0;
          if (m_sync) begin m_phase = 0; m_pv = 1; end
          else m_phase = (m_phase + 1) % 8;
          m_strobe = (m_phase == 0) && m_pv;
        end else begin
          m_halt = 1;
        end
      end else begin
        if (m_pos == C1 + G1 + C2 - 1) m_sync = sync_pad;
        m_pos++;
        if (run) m_pend = 0;
        else if (step) m_pend = 1;
      end
    end
  end

  function automatic logic [8:0] exp_vec();
    logic e1, e2;
    e1 = (m_pos < C1);
    e2 = (m_pos >= C1 + G1) && (m_pos < C1 + G1 + C2);
    return {m_pocp, e1, e2, m_halt, m_pv, m_strobe, 3'(m_phase)};
  endfunction

  always @(negedge sysclk) begin
    checks++;
    if (clk1_pad === 1'b1 && clk2_pad === 1'b1) begin
      errors++;
      $display("FAIL overlap: clk1_pad=%b clk2_pad=%b both high at %0t", clk1_pad, clk2_pad, $time);
    end
  end

  task automatic wait_pos(input int pos, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge sysclk);
      if (m_pos == pos && !m_halt) ok = 1;
    end
  endtask

  task automatic test_reset();
    poc = 1; run = 0; step = 0; sync_pad = 0;
    repeat (3) @(negedge sysclk);
    checks++;
    if (dut_vec !== 9'b1_0000_0000) begin
      errors++; $display("FAIL reset_state: got %b expected %b", dut_vec, 9'b1_0000_0000);
    end
  endtask

  task automatic test_clock_waveform();
    int hi1, hi2;
    hi1 = 0; hi2 = 0;
    poc = 0; run = 1;
    @(negedge sysclk);
    tick_idx = 0;
    checks++;
    if (clk1_pad !== 1'b1) begin
      errors++; $display("FAIL first_c1: got clk1_pad=%b expected 1", clk1_pad);
    end
    hi1 += clk1_pad; hi2 += clk2_pad;
    for (int i = 1; i < 3 * PER; i++) begin
      @(negedge sysclk); tick_idx++;
      hi1 += clk1_pad; hi2 += clk2_pad;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL waveform tick %0d: got %b expected %b", tick_idx, dut_vec, exp_vec());
      end
    end
    checks++;
    if (hi1 != 3 * C1 || hi2 != 3 * C2) begin
      errors++; $display("FAIL high_ticks: got clk1=%0d clk2=%0d expected %0d %0d", hi1, hi2, 3 * C1, 3 * C2);
    end
  endtask

  task automatic test_poc();
    int fall_at;
    logic prev_low;
    fall_at = -1; prev_low = 0;
    while (tick_idx < 320 && fall_at < 0) begin
      prev_low = !clk1_pad && !clk2_pad;
      @(negedge sysclk); tick_idx++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL poc_model tick %0d: got %b expected %b", tick_idx, dut_vec, exp_vec());
      end
      if (poc_pad === 1'b0) fall_at = tick_idx;
    end
    checks++;
    if (fall_at != POCN * PER) begin
      errors++; $display("FAIL poc_fall: got tick %0d expected %0d", fall_at, POCN * PER);
    end
    checks++;
    if (!prev_low) begin
      errors++; $display("FAIL poc_clocks_low: got clocks active before fall, expected both low");
    end
  endtask

  task automatic test_phase();
    bit ok;
    wait_pos(C1 + G1, 3 * PER, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL phase_wait_c2: got timeout expected C2"); end
    sync_pad = 1;
    wait_pos(C1 + G1 + C2, 2 * PER, ok);
    sync_pad = 0;
    for (int k = 0; k <= 8; k++) begin
      wait_pos(0, 2 * PER, ok);
      checks++;
      if (!ok || phase !== 3'(k % 8) || cycle_strobe !== (k % 8 == 0) || phase_valid !== 1'b1) begin
        errors++;
        $display("FAIL phase_seq k=%0d: got phase=%0d strobe=%b valid=%b expected %0d %b 1",
                 k, phase, cycle_strobe, phase_valid, k % 8, k % 8 == 0);
      end
    end
  endtask

  task automatic test_halt_step();
    bit ok;
    int hi1, ph0;
    wait_pos(5, 3 * PER, ok);
    run = 0;
    for (int i = 1; i <= PER - 5; i++) begin
      @(negedge sysclk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL halt_model i=%0d: got %b expected %b", i, dut_vec, exp_vec());
      end
      if (i == PER - 6 && halted !== 1'b0) begin
        errors++; $display("FAIL halt_early: got halted=%b expected 0", halted);
      end
    end
    checks++;
    if (!(halted === 1'b1 && clk1_pad === 1'b0 && clk2_pad === 1'b0)) begin
      errors++; $display("FAIL halt_entry: got halted=%b clk1=%b clk2=%b expected 1 0 0", halted, clk1_pad, clk2_pad);
    end
    repeat ($urandom_range(5, 30)) @(negedge sysclk);
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_hold: got halted=%b expected 1", halted); end
    ph0 = m_phase;
    step = 1;
    @(negedge sysclk);
    step = 0;
    checks++;
    if (clk1_pad !== 1'b1 || halted !== 1'b0) begin
      errors++; $display("FAIL step_start: got clk1=%b halted=%b expected 1 0", clk1_pad, halted);
    end
    hi1 = 1;
    for (int j = 1; j <= PER; j++) begin
      @(negedge sysclk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL step_model j=%0d: got %b expected %b", j, dut_vec, exp_vec());
      end
      if (j < PER) hi1 += clk1_pad;
      if (j == PER - 1 && halted !== 1'b0) begin
        errors++; $display("FAIL step_short: got halted=%b expected 0", halted);
      end
    end
    checks++;
    if (halted !== 1'b1 || hi1 != C1 || phase !== 3'((ph0 + 1) % 8)) begin
      errors++; $display("FAIL step_period: got halted=%b clk1_ticks=%0d phase=%0d expected 1 %0d %0d",
                         halted, hi1, phase, C1, (ph0 + 1) % 8);
    end
  endtask

  task automatic test_back_to_back();
    int rises, halts;
    logic prev;
    run = 1; step = 1;
    @(negedge sysclk);
    step = 0;
    checks++;
    if (clk1_pad !== 1'b1 || halted !== 1'b0) begin
      errors++; $display("FAIL runstep_start: got clk1=%b halted=%b expected 1 0", clk1_pad, halted);
    end
    halts = 0;
    for (int i = 1; i < 2 * PER; i++) begin
      @(negedge sysclk);
      halts += halted;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL runstep_model i=%0d: got %b expected %b", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (halts != 0) begin errors++; $display("FAIL runstep_free: got %0d halted ticks expected 0", halts); end
    @(negedge sysclk);
    run = 0;
    rises = 0; prev = clk1_pad;
    for (int i = 0; i < 2 * PER; i++) begin
      @(negedge sysclk);
      if (clk1_pad === 1'b1 && prev !== 1'b1) rises++;
      prev = clk1_pad;
    end
    checks++;
    if (rises != 0 || halted !== 1'b1) begin
      errors++; $display("FAIL runstep_queue: got rises=%0d halted=%b expected 0 1", rises, halted);
    end
  endtask

  task automatic test_poc_midperiod();
    bit ok;
    run = 1;
    wait_pos(C1 + G1 + 6, 3 * PER, ok);
    poc = 1;
    @(negedge sysclk);
    checks++;
    if (clk2_pad !== 1'b0 || poc_pad !== 1'b1 || phase_valid !== 1'b0) begin
      errors++; $display("FAIL poc_mid: got clk2=%b poc_pad=%b valid=%b expected 0 1 0", clk2_pad, poc_pad, phase_valid);
    end
    poc = 0;
    @(negedge sysclk);
    checks++;
    if (clk1_pad !== 1'b1) begin errors++; $display("FAIL poc_release: got clk1=%b expected 1", clk1_pad); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2500; i++) begin
      @(negedge sysclk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random i=%0d: got %b expected %b", i, dut_vec, exp_vec());
      end
      if ($urandom_range(0, 149) == 0) run = ~run;
      step = ($urandom_range(0, 39) == 0);
      sync_pad = ($urandom_range(0, 5) == 0);
      poc = ($urandom_range(0, 999) == 0);
    end
    poc = 0; step = 0;
  endtask

  initial begin
    test_reset();
    test_clock_waveform();
    test_poc();
    test_phase();
    test_halt_step();
    test_back_to_back();
    test_poc_midperiod();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
